game_link_tx: RTL and testbench

- Serial transmitter for the two-board link: sends game events from this board to the opponent board over an 8N1 UART line.
- Sits beside the state machine and score counter, in the pclk domain.
- Sends a START message when the local player clicks "play", and a SCORE message carrying the local score when the game ends.
- The opponent's receiver decodes these messages into its uart_start and op_score signals.

---
 rtl/game_link_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 68 ++++++
 rtl/game_link_tx.sv | 134 +++++++++++++
 tb/tb_game_link_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_link_pkg.sv
// Shared definitions for the two-board game link (transmitter and future receiver).
package game_link_pkg;

  // Message header bytes and the fixed START payload
  localparam logic [7:0] HDR_START     = 8'hA5;
  localparam logic [7:0] HDR_SCORE     = 8'h5A;
  localparam logic [7:0] START_PAYLOAD = 8'h01;

  // Number of bytes per message: header, payload, checksum
  localparam int unsigned MSG_BYTES = 3;

  typedef enum logic {
    MSG_START = 1'b0,
    MSG_SCORE = 1'b1
  } msg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_NEXT = 2'd2
  } state_t;

  // Header byte for a given message type
  function automatic logic [7:0] msg_header(input msg_t m);
    return (m == MSG_START) ? HDR_START : HDR_SCORE;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit.
// ready goes high one cycle before the stop bit ends (or when idle) so the
// caller can present the next byte with load in the following cycle and get
// a gapless back-to-back stream.
module uart_tx_byte
  import game_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 651
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    IDX_STOP = 4'd9;

  logic          active;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shreg;
  logic          last_cycle;

  assign last_cycle = active && (bit_idx == IDX_STOP) && (bit_cnt == CNT_LAST);
  assign ready      = !active || ((bit_idx == IDX_STOP) && (bit_cnt == CNT_PRE));

  // Bit timing and shifting; a new byte may be loaded when idle or in the final stop-bit cycle
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (load && (!active || last_cycle)) begin
      active  <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= data;
      tx      <= 1'b0;
    end else if (active) begin
      if (bit_cnt == CNT_LAST) begin
        bit_cnt <= '0;
        if (bit_idx == IDX_STOP) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx == 4'd8) begin
            tx <= 1'b1;
          end else begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
        end
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_link_tx.sv
// Game link transmitter: captures START/SCORE requests, arbitrates (START
// first), and sends 3-byte messages {header, payload, header^payload} over
// an 8N1 line with no gaps between bytes or between queued messages.
module game_link_tx
  import game_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 651
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       send_start,
  input  logic       send_score,
  input  logic [6:0] score,
  output logic       tx,
  output logic       busy,
  output logic       msg_done
);

  state_t     state;
  logic       start_pend;
  logic       score_pend;
  logic [6:0] score_latched;
  logic [7:0] hdr_q;
  logic [7:0] payload_q;
  logic [1:0] byte_idx;

  logic       byte_ready;
  logic       byte_load;
  logic [7:0] byte_data;
  logic       new_msg;
  msg_t       sel_msg;
  logic [7:0] new_hdr;
  logic [7:0] new_payload;

  // Message selection and next-byte mux for the serialiser
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value held, which would infer a latch.
    sel_msg     = start_pend ? MSG_START : MSG_SCORE;
    new_hdr     = msg_header(sel_msg);
    new_payload = (sel_msg == MSG_START) ? START_PAYLOAD : {1'b0, score_latched};
    new_msg     = (start_pend || score_pend) &&
                  ((state == ST_IDLE) ||
                   ((state == ST_NEXT) && (byte_idx == 2'(MSG_BYTES - 1))));
    byte_load   = new_msg || ((state == ST_NEXT) && (byte_idx != 2'(MSG_BYTES - 1)));
    byte_data   = new_hdr;
    if (!new_msg) begin
      case (byte_idx)
        2'd0:    byte_data = payload_q;
        2'd1:    byte_data = hdr_q ^ payload_q;
        default: byte_data = new_hdr;
      endcase
    end
  end

  // Pending flags and score latch; a new request wins over clearing on selection
  always_ff @(posedge pclk) begin
    if (rst) begin
      start_pend    <= 1'b0;
      score_pend    <= 1'b0;
      score_latched <= '0;
    end else begin
      if (send_start) begin
        start_pend <= 1'b1;
      end else if (new_msg && (sel_msg == MSG_START)) begin
        start_pend <= 1'b0;
      end
      if (send_score) begin
        score_pend    <= 1'b1;
        score_latched <= score;
      end else if (new_msg && (sel_msg == MSG_SCORE)) begin
        score_pend <= 1'b0;
      end
    end
  end

  // Message FSM: IDLE picks a message, SEND waits for the byte to near its end,
  // NEXT queues the following byte or finishes the message
  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hdr_q     <= '0;
      payload_q <= '0;
      byte_idx  <= '0;
      msg_done  <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (new_msg) begin
            hdr_q     <= new_hdr;
            payload_q <= new_payload;
            byte_idx  <= '0;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (byte_ready) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (byte_idx != 2'(MSG_BYTES - 1)) begin
            byte_idx <= byte_idx + 2'd1;
            state    <= ST_SEND;
          end else begin
            msg_done <= 1'b1;
            if (new_msg) begin
              hdr_q     <= new_hdr;
              payload_q <= new_payload;
              byte_idx  <= '0;
              state     <= ST_SEND;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = start_pend || score_pend || (state != ST_IDLE);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .pclk (pclk),
    .rst  (rst),
    .load (byte_load),
    .data (byte_data),
    .tx   (tx),
    .ready(byte_ready)
  );

endmodule

// File: tb/tb_game_link_tx.sv
// Self-checking bench for game_link_tx with CLKS_PER_BIT=4. A line decoder
// samples tx mid-bit and compares bytes against messages built from the
// message rules; timing of busy/msg_done is checked relative to requests.
module tb_game_link_tx;

  localparam int CPB = 4;
  localparam int MSG_CYC = 30 * CPB;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       send_start = 1'b0;
  logic       send_score = 1'b0;
  logic [6:0] score = '0;
  logic       tx;
  logic       busy;
  logic       msg_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done = -1;

  game_link_tx #(.CLKS_PER_BIT(CPB)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .send_start(send_start),
    .send_score(send_score),
    .score     (score),
    .tx        (tx),
    .busy      (busy),
    .msg_done  (msg_done)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Passive msg_done monitor, sampled just after each rising edge
  always begin
    @(posedge pclk);
    #1;
    if (msg_done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      last_done = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference message: header, payload, checksum
  function automatic logic [23:0] msg_bytes(input bit is_start, input logic [6:0] s);
    logic [7:0] h;
    logic [7:0] p;
    h = is_start ? 8'hA5 : 8'h5A;
    p = is_start ? 8'h01 : {1'b0, s};
    return {h, p, h ^ p};
  endfunction

  // Drive a one-cycle request; n is the cycle index at which it was driven
  task automatic pulse(input bit st, input bit sc, input logic [6:0] val, output int n);
    n = cyc;
    send_start = st;
    send_score = sc;
    if (sc) score = val;
    @(negedge pclk);
    send_start = 1'b0;
    send_score = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input int limit, output logic [7:0] b,
                           output int start_cyc);
    int waited;
    waited = 0;
    b = '0;
    start_cyc = -1;
    while (tx !== 1'b0 && waited < limit) begin
      @(negedge pclk);
      waited++;
    end
    check({tag, " start_found"}, 32'(tx === 1'b0), 32'd1);
    if (tx === 1'b0) begin
      start_cyc = cyc;
      @(negedge pclk);
      check({tag, " start_bit"}, 32'(tx), 32'd0);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge pclk);
        b[k] = tx;
      end
      repeat (CPB) @(negedge pclk);
      check({tag, " stop_bit"}, 32'(tx), 32'd1);
    end
  endtask

  task automatic recv_msg(input string tag, input logic [23:0] exp, input int first_limit,
                          output int msg_start);
    logic [7:0] b;
    int s;
    int prev;
    prev = 0;
    msg_start = -1;
    for (int i = 0; i < 3; i++) begin
      recv_byte($sformatf("%s b%0d", tag, i), (i == 0) ? first_limit : 2 * CPB, b, s);
      if (i == 0) msg_start = s;
      else check($sformatf("%s gap%0d", tag, i), 32'(s - prev), 32'(10 * CPB));
      prev = s;
      check($sformatf("%s byte%0d", tag, i), 32'(b), 32'(exp[23 - 8 * i -: 8]));
    end
  endtask

  // Line must stay quiet for n cycles
  task automatic idle_quiet(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      if (tx !== 1'b1 || busy !== 1'b0 || msg_done !== 1'b0) bad++;
    end
    check({tag, " quiet_cycles_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge pclk);
  endtask

  initial begin
    int n, t0, t1, d0, nd;
    logic [6:0] s;
    bit both;

    // Reset and idle
    repeat (3) @(negedge pclk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset msg_done", 32'(msg_done), 32'd0);
    rst = 1'b0;
    idle_quiet("idle100", 100);

    // START message with exact timing
    d0 = done_cnt;
    pulse(1'b1, 1'b0, 7'd0, n);
    check("start busy_rise", 32'(busy), 32'd1);
    check("start tx_still_high", 32'(tx), 32'd1);
    recv_msg("start", msg_bytes(1'b1, 7'd0), 8, t0);
    check("start latency", 32'(t0 - n), 32'd2);
    wait_until(n + 121);
    check("start busy_before_done", 32'(busy), 32'd1);
    check("start no_early_done", 32'(msg_done), 32'd0);
    @(negedge pclk);
    check("start msg_done", 32'(msg_done), 32'd1);
    check("start busy_fall", 32'(busy), 32'd0);
    check("start done_cycle", 32'(last_done - n), 32'd122);
    @(negedge pclk);
    check("start done_one_cycle", 32'(msg_done), 32'd0);
    check("start done_count", 32'(done_cnt - d0), 32'd1);
    idle_quiet("after_start", 20);

    // SCORE 42
    d0 = done_cnt;
    pulse(1'b0, 1'b1, 7'd42, n);
    recv_msg("score42", msg_bytes(1'b0, 7'd42), 8, t0);
    wait_until(t0 + MSG_CYC + 1);
    check("score42 done_cycle", 32'(last_done - t0), 32'(MSG_CYC));
    check("score42 done_count", 32'(done_cnt - d0), 32'd1);
    idle_quiet("after_score42", 20);

    // START and SCORE together: START first, SCORE gapless
    d0 = done_cnt;
    pulse(1'b1, 1'b1, 7'd99, n);
    recv_msg("both start", msg_bytes(1'b1, 7'd0), 8, t0);
    recv_msg("both score", msg_bytes(1'b0, 7'd99), 2 * CPB, t1);
    check("both msg_gap", 32'(t1 - t0), 32'(MSG_CYC));
    wait_until(t1 + MSG_CYC + 1);
    check("both done_count", 32'(done_cnt - d0), 32'd2);
    idle_quiet("after_both", 20);

    // SCORE requests during START: merged, last score wins
    d0 = done_cnt;
    pulse(1'b1, 1'b0, 7'd0, n);
    fork
      begin
        recv_msg("merge start", msg_bytes(1'b1, 7'd0), 8, t0);
        recv_msg("merge score", msg_bytes(1'b0, 7'd9), 2 * CPB, t1);
      end
      begin
        int m;
        repeat (20) @(negedge pclk);
        pulse(1'b0, 1'b1, 7'd5, m);
        repeat (40) @(negedge pclk);
        pulse(1'b0, 1'b1, 7'd9, m);
      end
    join
    check("merge msg_gap", 32'(t1 - t0), 32'(MSG_CYC));
    wait_until(t1 + MSG_CYC + 1);
    idle_quiet("merge no_third", 100);
    check("merge done_count", 32'(done_cnt - d0), 32'd2);

    // Randomised requests against the reference message model
    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(1, 20)) @(negedge pclk);
      s = 7'($urandom_range(0, 127));
      both = 1'($urandom_range(0, 1));
      d0 = done_cnt;
      nd = both ? 2 : 1;
      pulse(both, 1'b1, s, n);
      t1 = -1;
      if (both) begin
        recv_msg($sformatf("rnd%0d start", it), msg_bytes(1'b1, 7'd0), 8, t0);
        recv_msg($sformatf("rnd%0d score", it), msg_bytes(1'b0, s), 2 * CPB, t1);
      end else begin
        recv_msg($sformatf("rnd%0d score", it), msg_bytes(1'b0, s), 8, t1);
      end
      wait_until(t1 + MSG_CYC + 1);
      check($sformatf("rnd%0d done_count", it), 32'(done_cnt - d0), 32'(nd));
      check($sformatf("rnd%0d busy_idle", it), 32'(busy), 32'd0);
    end

    // Reset in the middle of byte1 of a SCORE message
    d0 = done_cnt;
    pulse(1'b0, 1'b1, 7'd77, n);
    wait_until(n + 2 + 10 * CPB + 10);
    rst = 1'b1;
    @(negedge pclk);
    check("midrst tx", 32'(tx), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle_quiet("midrst no_resend", 150);
    check("midrst done_count", 32'(done_cnt - d0), 32'd0);

    // A fresh request after reset still works
    pulse(1'b0, 1'b1, 7'd3, n);
    recv_msg("post_rst", msg_bytes(1'b0, 7'd3), 8, t0);
    check("post_rst latency", 32'(t0 - n), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so a stuck design cannot hang the run
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
